awgn_channel: RTL

AWGN_CHANNEL -- requirements
Module: awgn_channel

---
 rtl/awgn_channel_pkg.sv | 27 ++
 rtl/awgn_lane.sv | 87 ++++++++
 rtl/awgn_channel.sv | 114 +++++++++++
 3 files changed

// File: rtl/awgn_channel_pkg.sv
// Shared QPSK channel definitions.
// Default widths and saturation bounds.
package awgn_channel_pkg;

  localparam int SIG_W_DEF   = 16;
  localparam int NOISE_W_DEF = 20;
  localparam int GAIN_W_DEF  = 16;
  localparam int SAT_CNT_W   = 16;

  localparam logic signed [SIG_W_DEF-1:0] SAT_MAX =
    16'sh7FFF;
  localparam logic signed [SIG_W_DEF-1:0] SAT_MIN =
    16'sh8000;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX =
    16'hFFFF;

  // Largest value of a w-bit two's complement word.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value of a w-bit two's complement word.
  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/awgn_lane.sv
// One I or Q lane of the AWGN channel.
// Scale noise, add to signal, clip to output range.
module awgn_lane
  import awgn_channel_pkg::*;
#(
  parameter int SIG_W   = SIG_W_DEF,
  parameter int NOISE_W = NOISE_W_DEF,
  parameter int GAIN_W  = GAIN_W_DEF
) (
  input  logic                      clk_fs,
  input  logic                      rst_n,
  input  logic                      en_s1,
  input  logic                      en_s2,
  input  logic                      en_s3,
  input  logic                      noise_en,
  input  logic signed [SIG_W-1:0]   sig,
  input  logic signed [NOISE_W-1:0] gauss,
  input  logic [GAIN_W-1:0]         gain,
  output logic signed [SIG_W-1:0]   out,
  output logic                      clip
);

  localparam int N_W   = NOISE_W + 1;
  localparam int SUM_W = NOISE_W + 2;
  localparam int P_W   = NOISE_W + GAIN_W + 1;

  localparam logic signed [SUM_W-1:0] HI =
    SUM_W'(sat_hi(SIG_W));
  localparam logic signed [SUM_W-1:0] LO =
    SUM_W'(sat_lo(SIG_W));
  localparam logic signed [SIG_W-1:0] OUT_HI =
    SIG_W'(sat_hi(SIG_W));
  localparam logic signed [SIG_W-1:0] OUT_LO =
    SIG_W'(sat_lo(SIG_W));

  logic signed [GAIN_W:0]    gain_s;
  logic signed [P_W-1:0]     prod;
  logic signed [N_W-1:0]     n_nxt;
  logic signed [SIG_W-1:0]   s1_sig;
  logic signed [N_W-1:0]     s1_n;
  logic signed [SUM_W-1:0]   s2_sum;
  logic                      over;
  logic                      under;

  // Gain is unsigned Q0.GAIN_W; widen with a zero sign bit.
  assign gain_s = {1'b0, gain};
  assign prod   = P_W'(gauss) * P_W'(gain_s);
  assign n_nxt  = noise_en ? N_W'(prod >>> GAIN_W) : '0;

  assign over  = s2_sum > HI;
  assign under = s2_sum < LO;
  assign clip  = over | under;

  // S1: capture signal and scaled noise.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      s1_sig <= '0;
      s1_n   <= '0;
    end else if (en_s1) begin
      s1_sig <= sig;
      s1_n   <= n_nxt;
    end
  end

  // S2: full-width sum, cannot overflow.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      s2_sum <= '0;
    end else if (en_s2) begin
      s2_sum <= SUM_W'(s1_sig) + SUM_W'(s1_n);
    end
  end

  // S3: clip into the output range.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (en_s3) begin
      unique case (1'b1)
        over:    out <= OUT_HI;
        under:   out <= OUT_LO;
        default: out <= s2_sum[SIG_W-1:0];
      endcase
    end
  end

endmodule

// File: rtl/awgn_channel.sv
// AWGN channel: adds scaled noise to QPSK I/Q.
// Valid pipeline, gain register, saturation stats.
module awgn_channel
  import awgn_channel_pkg::*;
#(
  parameter int SIG_W   = SIG_W_DEF,
  parameter int NOISE_W = NOISE_W_DEF,
  parameter int GAIN_W  = GAIN_W_DEF
) (
  input  logic                      clk_fs,
  input  logic                      rst_n,
  input  logic signed [SIG_W-1:0]   sig_I,
  input  logic signed [SIG_W-1:0]   sig_Q,
  input  logic                      sig_valid,
  input  logic signed [NOISE_W-1:0] gauss_I,
  input  logic signed [NOISE_W-1:0] gauss_Q,
  input  logic                      noise_en,
  input  logic [GAIN_W-1:0]         noise_gain,
  input  logic                      gain_load,
  input  logic                      sat_clr,
  output logic signed [SIG_W-1:0]   out_I,
  output logic signed [SIG_W-1:0]   out_Q,
  output logic                      out_valid,
  output logic [SAT_CNT_W-1:0]      sat_cnt,
  output logic                      sat_flag
);

  logic [GAIN_W-1:0] gain_reg;
  logic              v1;
  logic              v2;
  logic              v3;
  logic              clip_I;
  logic              clip_Q;
  logic              sat_evt;

  // One event per sample, even if both lanes clip.
  assign sat_evt   = v2 & (clip_I | clip_Q);
  assign out_valid = v3;

  // Gain register; zero after reset keeps noise off.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      gain_reg <= '0;
    end else if (gain_load) begin
      gain_reg <= noise_gain;
    end
  end

  // Valid bits travel alongside the lane stages.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= sig_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Saturation stats; clear beats a same-cycle event.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (sat_clr) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (sat_evt) begin
      sat_flag <= 1'b1;
      if (sat_cnt != SAT_CNT_MAX) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

  awgn_lane #(
    .SIG_W   (SIG_W),
    .NOISE_W (NOISE_W),
    .GAIN_W  (GAIN_W)
  ) u_lane_i (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .en_s1    (sig_valid),
    .en_s2    (v1),
    .en_s3    (v2),
    .noise_en (noise_en),
    .sig      (sig_I),
    .gauss    (gauss_I),
    .gain     (gain_reg),
    .out      (out_I),
    .clip     (clip_I)
  );

  awgn_lane #(
    .SIG_W   (SIG_W),
    .NOISE_W (NOISE_W),
    .GAIN_W  (GAIN_W)
  ) u_lane_q (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .en_s1    (sig_valid),
    .en_s2    (v1),
    .en_s3    (v2),
    .noise_en (noise_en),
    .sig      (sig_Q),
    .gauss    (gauss_Q),
    .gain     (gain_reg),
    .out      (out_Q),
    .clip     (clip_Q)
  );

endmodule
